// File: rtl/param_multi_bit_fifo.sv
// Parametrised single-clock FIFO with occupancy, thresholds and sticky errors.
// Optional first-word-fall-through read port enabled by defining FIFO_FWFT_EN.
module param_multi_bit_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic                       wr,
   input  logic                       rd,
   output logic [DATA_WIDTH-1:0]      dout,
   output logic                       dout_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr_n;
   logic [PW-1:0]         rd_ptr_n;
   logic [PW-1:0]         cnt_n;
   logic                  wr_ok;
   logic                  rd_ok;

   // Accept decisions use the registered flags; a pop frees a slot for a write at full.
   always_comb begin
      wr_ok    = wr && (!full || rd);
      rd_ok    = rd && !empty;
      wr_ptr_n = wr_ptr + PW'(wr_ok);
      rd_ptr_n = rd_ptr + PW'(rd_ok);
      cnt_n    = wr_ptr_n - rd_ptr_n;
   end

   // Pointers, occupancy, flags and sticky errors, all from next-state pointers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_n;
         rd_ptr       <= rd_ptr_n;
         count        <= cnt_n;
         full         <= (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) &&
                         (wr_ptr_n[AW] != rd_ptr_n[AW]);
         empty        <= (wr_ptr_n == rd_ptr_n);
         almost_full  <= (cnt_n >= PW'(AF_THRESH));
         almost_empty <= (cnt_n <= PW'(AE_THRESH));
         if (wr && !wr_ok)
            overflow <= 1'b1;
         if (rd && !rd_ok)
            underflow <= 1'b1;
      end
   end

   // Storage array; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr[AW-1:0]] <= din;
   end

`ifdef FIFO_FWFT_EN
   // Head word is presented combinationally whenever the FIFO holds data.
   always_comb begin
      dout       = mem[rd_ptr[AW-1:0]];
      dout_valid = !empty;
   end
`else
   // Registered read: popped word appears one cycle after the accepted read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= rd_ok;
         if (rd_ok)
            dout <= mem[rd_ptr[AW-1:0]];
      end
   end
`endif

endmodule

// File: tb/tb_param_multi_bit_fifo.sv
// Scoreboard bench for param_multi_bit_fifo in its default registered-read build.
// Directed vectors; popped words are queued and checked by a separate monitor.
module tb_param_multi_bit_fifo;

   localparam int DW = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [DW-1:0] din = '0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [3:0]    count;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   logic          ovf_m = 1'b0;
   logic          unf_m = 1'b0;

   param_multi_bit_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .AF_THRESH(6),
      .AE_THRESH(2)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .din(din),
      .wr(wr),
      .rd(rd),
      .dout(dout),
      .dout_valid(dout_valid),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every presented word must match the oldest expected pop.
   always @(negedge clk) begin
      if (resetn) begin
         if (dout_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got %0h expected none", dout);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (dout !== e) begin
                  errors++;
                  $display("FAIL dout got %0h expected %0h at %0t", dout, e, $time);
               end
            end
         end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_valid got none expected %0h at %0t",
                     exp_q[0], $time);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic check_flags();
      int n;
      n = mq.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= 6));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("underflow", 32'(underflow), 32'(unf_m));
   endtask

   task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
      logic wa;
      logic ra;
      logic [DW-1:0] popped;
      wa = w && (mq.size() != DEPTH || r);
      ra = r && (mq.size() != 0);
      popped = '0;
      if (ra)
         popped = mq.pop_front();
      if (wa)
         mq.push_back(d);
      if (w && !wa)
         ovf_m = 1'b1;
      if (r && !ra)
         unf_m = 1'b1;
      wr = w;
      rd = r;
      din = d;
      @(posedge clk);
      if (ra)
         exp_q.push_back(popped);
      #1;
      check_flags();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      wr = 1'b0;
      rd = 1'b0;
      resetn = 1'b0;
      #1;
      mq.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_dout_valid", 32'(dout_valid), 32'h0);
      check_flags();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rst_pending got %0d expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   logic [DW-1:0] t2 [5];

   initial begin
      t2 = '{8'd0, 8'd5, 8'd3, 8'd6, 8'd6};
      do_reset();

      foreach (t2[i]) cyc(1'b1, 1'b0, t2[i]);
      repeat (5) cyc(1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
      cyc(1'b1, 1'b0, 8'hFF);
      repeat (8) cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
      repeat (6) cyc(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
      repeat (8) cyc(1'b0, 1'b1, 8'h00);

      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
      cyc(1'b1, 1'b1, 8'h55);
      repeat (8) cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 8'h77);
      cyc(1'b0, 1'b1, 8'h00);

      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
      do_reset();
      cyc(1'b1, 1'b0, 8'h5A);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);

      repeat (3) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
